posit_classifier_pipe: RTL and testbench

- Pipelined, multi-operand posit classifier with valid/ready handshake, tag passthrough and flush.
- Per operand it produces:
  - zero / NaR / sign flags;
  - saturation flags (maxpos, minpos magnitude);
  - the signed scale (regime·2^ES + exponent).
- Sits at the front of the posit FPU op-groups, feeding class/compare ops and special-case bypass logic in downstream units.

---
 rtl/posit_pkg.sv | 41 ++++
 rtl/posit_scale_decode.sv | 65 ++++++
 rtl/posit_classifier_pipe.sv | 122 ++++++++++++
 tb/tb_posit_classifier_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit types and format helpers for the posit front-end classifier.
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT16_ES1 = 2'd0,
    POSIT8_ES0  = 2'd1,
    POSIT32_ES2 = 2'd2,
    POSIT16_ES2 = 2'd3
  } posit_format_e;

  typedef struct packed {
    logic is_zero;
    logic is_NaR;
    logic is_pos;
    logic is_neg;
    logic is_maxpos;
    logic is_minpos;
  } posit_class_t;

  function automatic int unsigned posit_width(posit_format_e f);
    case (f)
      POSIT8_ES0:  return 8;
      POSIT32_ES2: return 32;
      default:     return 16;
    endcase
  endfunction

  function automatic int unsigned exp_bits(posit_format_e f);
    case (f)
      POSIT16_ES1: return 1;
      POSIT8_ES0:  return 0;
      default:     return 2;
    endcase
  endfunction

  // Signed scale spans +/-(WIDTH-2)*2^ES plus exponent, so clog2(WIDTH)+ES+1 bits suffice.
  function automatic int unsigned scale_width(posit_format_e f);
    return $clog2(posit_width(f)) + exp_bits(f) + 1;
  endfunction

endpackage

// File: rtl/posit_scale_decode.sv
// Combinational single-operand posit classifier: special-value flags plus signed scale.
module posit_scale_decode
  import posit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ES    = 1,
  localparam int unsigned SCALE_W = $clog2(WIDTH) + ES + 1
) (
  input  logic [WIDTH-1:0]   operand,
  output posit_class_t       cls,
  output logic [SCALE_W-1:0] scale
);

  localparam int unsigned BW = WIDTH - 1;

  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    body;
  logic             regime_bit;
  logic             run_done;
  logic             zero_op;
  logic             nar_op;
  int               run;
  int               k;
  int               exp_val;
  int               pos;
  int               scale_int;

  always_comb begin
    mag        = operand[WIDTH-1] ? WIDTH'(-operand) : operand;
    body       = mag[BW-1:0];
    regime_bit = body[BW-1];
    zero_op    = (operand == '0);
    nar_op     = (operand == {1'b1, {BW{1'b0}}});

    // Regime: count leading bits equal to the first bit after the sign.
    run      = 0;
    run_done = 1'b0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!run_done && (body[i] == regime_bit)) run = run + 1;
      else run_done = 1'b1;
    end
    k = regime_bit ? (run - 1) : -run;

    // Exponent starts after the terminating bit; bits past the LSB read as zero.
    exp_val = 0;
    pos     = 0;
    for (int j = 0; j < int'(ES); j++) begin
      pos     = int'(BW) - 2 - run - j;
      exp_val = exp_val << 1;
      if (pos >= 0) exp_val = exp_val | (int'(body >> pos) & 1);
    end
    scale_int = k * (1 << ES) + exp_val;

    cls           = '0;
    cls.is_zero   = zero_op;
    cls.is_NaR    = nar_op;
    cls.is_pos    = !operand[WIDTH-1] && !zero_op;
    cls.is_neg    = operand[WIDTH-1] && !nar_op;
    cls.is_maxpos = (mag == {1'b0, {BW{1'b1}}});
    cls.is_minpos = (mag == WIDTH'(1));

    scale = (zero_op || nar_op) ? '0 : SCALE_W'(scale_int);
  end

endmodule

// File: rtl/posit_classifier_pipe.sv
// Multi-operand posit classifier with a valid/ready pipeline, tag passthrough and flush.
module posit_classifier_pipe
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat     = posit_format_e'(0),
  parameter int unsigned   NumOperands = 2,
  parameter int unsigned   NumPipeRegs = 1,
  parameter type           TagType     = logic,
  localparam int unsigned  WIDTH       = posit_width(pFormat),
  localparam int unsigned  ES          = exp_bits(pFormat),
  localparam int unsigned  SCALE_W     = scale_width(pFormat)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic        [NumOperands-1:0][WIDTH-1:0]    operands_i,
  input  TagType                                      tag_i,
  input  logic                                        in_valid_i,
  output logic                                        in_ready_o,
  output posit_class_t [NumOperands-1:0]              class_o,
  output logic signed [NumOperands-1:0][SCALE_W-1:0]  scale_o,
  output TagType                                      tag_o,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i,
  output logic                                        busy_o
);

  posit_class_t [NumOperands-1:0]              dec_class;
  logic         [NumOperands-1:0][SCALE_W-1:0] dec_scale;

  for (genvar g = 0; g < NumOperands; g++) begin : g_dec
    posit_scale_decode #(
      .WIDTH (WIDTH),
      .ES    (ES)
    ) u_dec (
      .operand (operands_i[g]),
      .cls     (dec_class[g]),
      .scale   (dec_scale[g])
    );
  end

  if (NumPipeRegs == 0) begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, flush_i};

    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign class_o     = dec_class;
    assign scale_o     = dec_scale;
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic         [N-1:0]                                valid_q;
    posit_class_t [N-1:0][NumOperands-1:0]               class_q;
    logic         [N-1:0][NumOperands-1:0][SCALE_W-1:0]  scale_q;
    TagType                                              tag_q [N];

    logic         [N-1:0]                                stage_ready;
    logic         [N-1:0]                                up_valid;
    posit_class_t [N-1:0][NumOperands-1:0]               up_class;
    logic         [N-1:0][NumOperands-1:0][SCALE_W-1:0]  up_scale;
    TagType                                              up_tag [N];

    // A stage can load unless it and every stage after it are full and the sink stalls.
    always_comb begin
      logic all_full;
      all_full    = 1'b1;
      stage_ready = '0;
      for (int s = N - 1; s >= 0; s--) begin
        all_full       = all_full & valid_q[s];
        stage_ready[s] = out_ready_i || !all_full;
      end
    end

    // Source of each stage: the decoders for stage 0, the previous stage otherwise.
    always_comb begin
      up_valid    = '0;
      up_class    = '0;
      up_scale    = '0;
      up_valid[0] = in_valid_i;
      up_class[0] = dec_class;
      up_scale[0] = dec_scale;
      up_tag[0]   = tag_i;
      for (int s = 1; s < int'(N); s++) begin
        up_valid[s] = valid_q[s-1];
        up_class[s] = class_q[s-1];
        up_scale[s] = scale_q[s-1];
        up_tag[s]   = tag_q[s-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        class_q <= '0;
        scale_q <= '0;
        for (int s = 0; s < int'(N); s++) tag_q[s] <= '0;
      end else begin
        for (int s = 0; s < int'(N); s++) begin
          if (flush_i) valid_q[s] <= 1'b0;
          else if (stage_ready[s]) valid_q[s] <= up_valid[s];
          // Payload only moves with a valid transaction; flush leaves it in place.
          if (stage_ready[s] && up_valid[s]) begin
            class_q[s] <= up_class[s];
            scale_q[s] <= up_scale[s];
            tag_q[s]   <= up_tag[s];
          end
        end
      end
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = valid_q[N-1];
    assign class_o     = class_q[N-1];
    assign scale_o     = scale_q[N-1];
    assign tag_o       = tag_q[N-1];
    assign busy_o      = |valid_q;
  end

endmodule

// File: tb/tb_posit_classifier_pipe.sv
// Self-checking bench for posit_classifier_pipe (16-bit, ES=1, two operands, two stages).
module tb_posit_classifier_pipe;
  import posit_pkg::*;

  localparam posit_format_e FMT = POSIT16_ES1;
  localparam int unsigned   SW  = scale_width(FMT);
  localparam int            ESB = 1;

  typedef logic [7:0] tag_t;

  typedef struct packed {
    logic [1:0][5:0]    cls;
    logic [1:0][SW-1:0] sc;
    tag_t               tag;
  } exp_t;

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic [1:0][15:0]            ops;
  tag_t                        tag_in;
  logic                        in_valid;
  logic                        in_ready;
  posit_class_t [1:0]          cls_out;
  logic signed [1:0][SW-1:0]   scale_out;
  tag_t                        tag_out;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  int   checks   = 0;
  int   failures = 0;
  int   outs     = 0;
  logic last_acc;
  exp_t q[$];

  posit_classifier_pipe #(
    .pFormat     (FMT),
    .NumOperands (2),
    .NumPipeRegs (2),
    .TagType     (tag_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .operands_i  (ops),
    .tag_i       (tag_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .class_o     (cls_out),
    .scale_o     (scale_out),
    .tag_o       (tag_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp_v);
    end
  endtask

  // Reference decode from the posit definition, walking bits with integer arithmetic.
  function automatic void ref_decode(input logic [15:0] x, output logic [5:0] cls,
                                     output logic [SW-1:0] sc);
    int m, r, run, k, e, idx, scale;
    bit zero, nar, neg;
    zero = (x == 16'h0000);
    nar  = (x == 16'h8000);
    neg  = x[15];
    m    = neg ? (65536 - int'(x)) % 65536 : int'(x);
    r    = (m >> 14) & 1;
    run  = 0;
    while (run < 15 && ((m >> (14 - run)) & 1) == r) run++;
    k   = (r == 1) ? run - 1 : -run;
    idx = run + 1;
    e   = 0;
    for (int j = 0; j < ESB; j++)
      e = e * 2 + (((idx + j) < 15) ? ((m >> (14 - idx - j)) & 1) : 0);
    scale = (zero || nar) ? 0 : k * (2 ** ESB) + e;
    cls = {zero, nar, (!neg && !zero), (neg && !nar), (m == 32'h7FFF), (m == 1)};
    sc  = SW'(scale);
  endfunction

  function automatic exp_t make_exp(input logic [1:0][15:0] o, input tag_t t);
    exp_t e;
    logic [5:0]    c;
    logic [SW-1:0] s;
    for (int i = 0; i < 2; i++) begin
      ref_decode(o[i], c, s);
      e.cls[i] = c;
      e.sc[i]  = s;
    end
    e.tag = t;
    return e;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] sp [8];
    sp = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h8001, 16'h4000, 16'hC000};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 7)];
    return 16'($urandom);
  endfunction

  // One clock: check outputs against the model, then advance the model with the handshakes.
  task automatic cycle();
    logic fire;
    exp_t e;
    #1;
    last_acc = in_valid && in_ready;
    fire     = out_valid && out_ready;
    chk("busy", 64'(busy), 64'(q.size() != 0));
    if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'(0));
    if (!out_ready) chk("in_ready_stall", 64'(in_ready), 64'(q.size() < 2));
    if (out_valid && q.size() != 0) begin
      e = q[0];
      chk("class0", 64'(cls_out[0]), 64'(e.cls[0]));
      chk("class1", 64'(cls_out[1]), 64'(e.cls[1]));
      chk("scale0", 64'(scale_out[0]), 64'(e.sc[0]));
      chk("scale1", 64'(scale_out[1]), 64'(e.sc[1]));
      chk("tag", 64'(tag_out), 64'(e.tag));
    end
    if (rst) q.delete();
    else begin
      if (fire && q.size() != 0) begin
        void'(q.pop_front());
        outs++;
      end
      if (flush) q.delete();
      else if (last_acc) q.push_back(make_exp(ops, tag_in));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    #1;
    chk({name, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({name, "_class"}, 64'(cls_out), 64'(0));
    chk({name, "_scale"}, 64'(scale_out), 64'(0));
    chk({name, "_tag"}, 64'(tag_out), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic drain(input string name);
    int n;
    n         = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk(name, 64'(q.size()), 64'(0));
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input tag_t t);
    in_valid = 1'b1;
    ops[0]   = a;
    ops[1]   = b;
    tag_in   = t;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    int   c, sent, outs0;
    rst       = 1'b1;
    flush     = 1'b0;
    ops       = '0;
    tag_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;

    // Zero and NaR with latency check.
    send(16'h0000, 16'h8000, 8'hA1);
    #1 chk("t1_valid_after_1", 64'(out_valid), 64'(0));
    cycle();
    #1 chk("t1_valid_after_2", 64'(out_valid), 64'(1));
    drain("t1_drain");

    // Saturation cases.
    send(16'h7FFF, 16'h0001, 8'h21);
    send(16'hFFFF, 16'h8001, 8'h22);
    drain("t2_drain");

    // Regime/exponent boundaries with ordered tags.
    send(16'h4000, 16'hC000, 8'h01);
    send(16'h5000, 16'h3000, 8'h02);
    drain("t3_drain");

    // Back-to-back stream with a stalled sink in the middle.
    sent  = 0;
    c     = 0;
    outs0 = outs;
    while ((sent < 6 || q.size() != 0) && c < 40) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 6);
      ops[0]    = rand_op();
      ops[1]    = rand_op();
      tag_in    = 8'(8'h41 + sent);
      cycle();
      if (last_acc) sent++;
      c++;
    end
    in_valid = 1'b0;
    chk("t4_all_out", 64'(outs - outs0), 64'(6));

    // Flush with a same-cycle input accept.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 8'h51);
    send(16'h2345, 16'h5432, 8'h52);
    out_ready = 1'b1;
    flush     = 1'b1;
    send(16'h3456, 16'h6543, 8'h53);
    flush = 1'b0;
    #1 chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    outs0 = outs;
    repeat (5) cycle();
    chk("t5_nothing_emerges", 64'(outs - outs0), 64'(0));

    // Reset mid-stream with a stalled output.
    out_ready = 1'b0;
    send(16'h0101, 16'hF0F0, 8'h61);
    send(16'h0202, 16'hE0E0, 8'h62);
    cycle();
    rst      = 1'b1;
    in_valid = 1'b1;
    ops      = {16'h1111, 16'h2222};
    tag_in   = 8'h63;
    cycle();
    in_valid = 1'b0;
    check_reset_outputs("t6_rst");
    rst       = 1'b0;
    out_ready = 1'b1;
    send(16'h6000, 16'hA000, 8'h64);
    #1 chk("t6_valid_after_1", 64'(out_valid), 64'(0));
    cycle();
    #1 chk("t6_valid_after_2", 64'(out_valid), 64'(1));
    drain("t6_drain");

    // Randomised traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      ops[0]    = rand_op();
      ops[1]    = rand_op();
      tag_in    = 8'($urandom);
      cycle();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
